// File: rtl/lpc_pkg.sv
// Shared LPC-path constants: filter order, lag index width, float constants and state encoding.
// Latency: n/a (package only).
// Backpressure: n/a.
package lpc_pkg;

    localparam int          LPC_ORDER = 12;
    localparam int          LAG_W     = 4;
    localparam logic [31:0] FP_ONE    = 32'h3f800000;
    localparam logic [31:0] FP_ZERO   = 32'h00000000;

    // Same encoding is used by the Durbin stage to recognise accumulate vs emit phases.
    typedef enum logic {
        S_ACCUM = 1'b0,
        S_EMIT  = 1'b1
    } lpc_state_t;

endpackage

// File: rtl/int_to_float.sv
// Signed integer to IEEE-754 single conversion, truncating the mantissa toward zero.
// Latency: one registered cycle.
// Backpressure: none; the output register holds while iEnable is low.
module int_to_float
    import lpc_pkg::*;
#(
    parameter int ACC_WIDTH = 48
)(
    input  logic                 iClock,
    input  logic                 iEnable,
    input  logic [ACC_WIDTH-1:0] iData,
    output logic [31:0]          oFloat
);

    localparam int PW = $clog2(ACC_WIDTH);

    logic [ACC_WIDTH-1:0] mag;
    logic [ACC_WIDTH-1:0] norm;
    logic [PW-1:0]        lead;
    logic [7:0]           exponent;
    logic [22:0]          mantissa;
    logic [31:0]          packed_f;

    // Magnitude, leading-one position, normalise so the leading one sits at the MSB, then pack.
    always_comb begin
        mag  = iData[ACC_WIDTH-1] ? -iData : iData;
        lead = '0;
        // Ascending scan: the last set bit seen is the leading one.
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (mag[i]) begin
                lead = PW'(i);
            end
        end
        norm     = mag << (PW'(ACC_WIDTH - 1) - lead);
        // Bits below the leading one; anything under the top 23 is dropped (round toward zero).
        mantissa = 23'(norm >> (ACC_WIDTH - 24));
        exponent = 8'd127 + 8'(lead);
        packed_f = (mag == '0) ? FP_ZERO : {iData[ACC_WIDTH-1], exponent, mantissa};
    end

    // Output register, frozen by the shared clock enable.
    always_ff @(posedge iClock) begin
        if (iEnable) begin
            oFloat <= packed_f;
        end
    end

endmodule

// File: rtl/acf_stream_generator.sv
// Block autocorrelation for lags 0..ORDER, streamed as IEEE-754 singles into the Durbin stage.
// Latency: lag 0 appears two cycles after the last sample of a block is consumed; ORDER+1 words back to back.
// Backpressure: none downstream; oReady drops for the emission window, everything freezes while iEnable is low.
module acf_stream_generator
    import lpc_pkg::*;
#(
    parameter int ORDER      = LPC_ORDER,
    parameter int BLOCK_SIZE = 4096,
    parameter int ACC_WIDTH  = 48
)(
    input  logic                iClock,
    input  logic                iReset,
    input  logic                iEnable,
    input  logic signed [15:0]  iSample,
    input  logic                iValid,
    output logic                oReady,
    output logic [31:0]         oACF,
    output logic [LAG_W-1:0]    oLag,
    output logic                oValid,
    output logic                oDone
);

    localparam int               CNT_W     = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [LAG_W-1:0] LAST_LAG  = LAG_W'(ORDER);
    // One extra emit cycle lets the last word leave the converter before the block is cleared.
    localparam logic [LAG_W-1:0] DRAIN_PTR = LAG_W'(ORDER + 1);

    lpc_state_t               state;
    logic [LAG_W-1:0]         ptr;
    logic [CNT_W-1:0]         cnt;
    logic                     consume;
    logic                     blk_clr;
    logic signed [15:0]       hist    [1:ORDER];
    logic [ACC_WIDTH-1:0]     acc_vec [0:ORDER];
    logic [ACC_WIDTH-1:0]     acc_sel;
    logic [ACC_WIDTH-1:0]     conv_in;
    logic                     conv_en;

    assign consume = iEnable & iValid & oReady;
    assign blk_clr = iEnable & (state == S_EMIT) & (ptr == DRAIN_PTR);

    // Sample history x[n-1]..x[n-ORDER]; zeroed between blocks so nothing carries across.
    always_ff @(posedge iClock) begin
        if (iReset || blk_clr) begin
            for (int i = 1; i <= ORDER; i++) begin
                hist[i] <= '0;
            end
        end else if (consume) begin
            hist[1] <= iSample;
            for (int i = 2; i <= ORDER; i++) begin
                hist[i] <= hist[i-1];
            end
        end
    end

    // One multiply-accumulate per lag; lag 0 squares the incoming sample.
    for (genvar l = 0; l <= ORDER; l++) begin : g_lag
        logic signed [15:0]          tap;
        logic signed [31:0]          prod;
        logic signed [ACC_WIDTH-1:0] acc_q;

        if (l == 0) begin : g_self
            assign tap = iSample;
        end else begin : g_hist
            assign tap = hist[l];
        end

        assign prod       = 32'(iSample) * 32'(tap);
        assign acc_vec[l] = acc_q;

        // Accumulate the sign-extended product; width is sized so no overflow can occur.
        always_ff @(posedge iClock) begin
            if (iReset || blk_clr) begin
                acc_q <= '0;
            end else if (consume) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
            end
        end
    end

    // Reset loads zero into the converter register so oACF comes out of reset cleared,
    // even with iEnable low.
    assign acc_sel = (ptr <= LAST_LAG) ? acc_vec[ptr] : '0;
    assign conv_in = iReset ? '0 : acc_sel;
    assign conv_en = iEnable | iReset;

    int_to_float #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_i2f (
        .iClock  (iClock),
        .iEnable (conv_en),
        .iData   (conv_in),
        .oFloat  (oACF)
    );

    // Block FSM: count samples, then walk the lag pointer; output strobes line up with the converter register.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state  <= S_ACCUM;
            ptr    <= '0;
            cnt    <= '0;
            oReady <= 1'b1;
            oValid <= 1'b0;
            oDone  <= 1'b0;
            oLag   <= '0;
        end else if (iEnable) begin
            oValid <= (state == S_EMIT) && (ptr <= LAST_LAG);
            oDone  <= (state == S_EMIT) && (ptr == LAST_LAG);
            if ((state == S_EMIT) && (ptr <= LAST_LAG)) begin
                oLag <= ptr;
            end
            case (state)
                S_ACCUM: begin
                    if (consume) begin
                        if (cnt == LAST_CNT) begin
                            state  <= S_EMIT;
                            oReady <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (ptr == DRAIN_PTR) begin
                        state  <= S_ACCUM;
                        ptr    <= '0;
                        oReady <= 1'b1;
                    end else begin
                        ptr <= ptr + LAG_W'(1);
                    end
                end
                default: begin
                    state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acf_stream_generator.sv
`timescale 1ns/1ps
module tb_acf_stream_generator;

    localparam int N   = 16;
    localparam int ORD = 12;
    localparam int NW  = ORD + 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               vld;
    logic signed [15:0] smp;
    logic               rdy;
    logic               ovld;
    logic               odone;
    logic [31:0]        oacf;
    logic [3:0]         olag;

    acf_stream_generator #(
        .ORDER      (ORD),
        .BLOCK_SIZE (N),
        .ACC_WIDTH  (48)
    ) dut (
        .iClock  (clk),
        .iReset  (rst),
        .iEnable (en),
        .iSample (smp),
        .iValid  (vld),
        .oReady  (rdy),
        .oACF    (oacf),
        .oLag    (olag),
        .oValid  (ovld),
        .oDone   (odone)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          ncyc   = 0;
    int          stray_done = 0;
    logic [31:0] cap_acf[$];
    int          cap_lag[$];
    bit          cap_done[$];
    int          cap_cyc[$];
    bit          rdy_hist[int];
    int          blk[N];
    bit          rand_gaps = 0;

    // Cycle counter and word capture: a word counts when the downstream stage would take it (enable high).
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        rdy_hist[ncyc] = rdy;
        if (odone && !ovld) stray_done = stray_done + 1;
        if (!rst && en && ovld) begin
            cap_acf.push_back(oacf);
            cap_lag.push_back(int'(olag));
            cap_done.push_back(odone);
            cap_cyc.push_back(ncyc);
        end
    end

    // Reference: autocorrelation straight from its definition.
    function automatic longint ref_acf(int l);
        longint s = 0;
        for (int n = l; n < N; n++) s += longint'(blk[n]) * longint'(blk[n - l]);
        return s;
    endfunction

    // Reference: integer to single precision, truncating, via plain arithmetic.
    function automatic logic [31:0] fconv(longint v);
        longint      m;
        longint      frac;
        int          p;
        logic [7:0]  e;
        if (v == 0) return 32'h0;
        m = (v < 0) ? -v : v;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        frac = m - (longint'(1) << p);
        if (p >= 23) frac = frac >> (p - 23);
        else         frac = frac << (23 - p);
        e = 8'(127 + p);
        return {(v < 0) ? 1'b1 : 1'b0, e, frac[22:0]};
    endfunction

    task automatic clear_cap();
        cap_acf.delete(); cap_lag.delete(); cap_done.delete(); cap_cyc.delete();
    endtask

    // Drive blk[] into the DUT; reports cycle indices of first and last consumed sample.
    task automatic send_block(input bit hold, output int t_first, output int t_last, output bit ok);
        int n = 0;
        int budget = 0;
        t_first = -1; t_last = -1; ok = 1;
        while (n < N) begin
            @(posedge clk); #1;
            en = 1; vld = 1; smp = 16'(blk[n]);
            if (rand_gaps) begin
                if ($urandom_range(0, 4) == 0) begin vld = 0; smp = 16'($urandom); end
                if ($urandom_range(0, 5) == 0) en = 0;
            end
            @(negedge clk); #1;
            if (vld && en && rdy) begin
                if (n == 0) t_first = ncyc;
                if (n == N - 1) t_last = ncyc;
                n++;
            end
            budget++;
            if (budget > 400) begin ok = 0; break; end
        end
        @(posedge clk); #1;
        en = 1;
        if (!hold) vld = 0;
    endtask

    task automatic wait_words(input int cnt, output bit ok);
        int budget = 0;
        ok = 1;
        while (cap_acf.size() < cnt) begin
            @(negedge clk); #1;
            budget++;
            if (budget > 300) begin ok = 0; break; end
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; vld = 0; smp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (rdy !== 1'b1)   begin errors++; $display("FAIL reset_rdy: got %b want 1", rdy); end
        checks++; if (ovld !== 1'b0)  begin errors++; $display("FAIL reset_vld: got %b want 0", ovld); end
        checks++; if (odone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", odone); end
        checks++; if (oacf !== 32'h0) begin errors++; $display("FAIL reset_acf: got %h want 00000000", oacf); end
        checks++; if (olag !== 4'd0)  begin errors++; $display("FAIL reset_lag: got %0d want 0", olag); end
        @(posedge clk); #1;
        rst = 0; en = 1;
    endtask

    task automatic test_all_ones();
        int tf, tl; bit ok, okw;
        for (int n = 0; n < N; n++) blk[n] = 1;
        clear_cap();
        send_block(0, tf, tl, ok);
        wait_words(NW, okw);
        checks++;
        if (!ok || !okw || cap_acf.size() != NW) begin
            errors++; $display("FAIL ones_count: got %0d words want %0d (send ok=%0b)", cap_acf.size(), NW, ok);
            return;
        end
        for (int l = 0; l < NW; l++) begin
            checks++;
            if (cap_acf[l] !== fconv(ref_acf(l)) || cap_lag[l] != l || cap_done[l] != (l == ORD) || cap_cyc[l] != tl + 2 + l) begin
                errors++;
                $display("FAIL ones_w%0d: acf=%h lag=%0d done=%0b cyc=%0d want acf=%h lag=%0d done=%0b cyc=%0d",
                         l, cap_acf[l], cap_lag[l], cap_done[l], cap_cyc[l], fconv(ref_acf(l)), l, (l == ORD), tl + 2 + l);
            end
        end
        checks++; if (cap_acf[0]  !== 32'h41800000) begin errors++; $display("FAIL ones_lag0: got %h want 41800000", cap_acf[0]); end
        checks++; if (cap_acf[1]  !== 32'h41700000) begin errors++; $display("FAIL ones_lag1: got %h want 41700000", cap_acf[1]); end
        checks++; if (cap_acf[12] !== 32'h40800000) begin errors++; $display("FAIL ones_lag12: got %h want 40800000", cap_acf[12]); end
        for (int c = tl + 1; c <= tl + ORD + 3; c++) begin
            checks++;
            if (rdy_hist[c] != (c == tl + ORD + 3)) begin
                errors++; $display("FAIL ones_rdy_c%0d: got %0b want %0b", c - tl, rdy_hist[c], (c == tl + ORD + 3));
            end
        end
    endtask

    task automatic test_alternating();
        int tf, tl; bit ok, okw;
        for (int n = 0; n < N; n++) blk[n] = (n % 2 == 0) ? 1 : -1;
        clear_cap();
        send_block(0, tf, tl, ok);
        wait_words(NW, okw);
        checks++;
        if (!ok || !okw || cap_acf.size() != NW) begin
            errors++; $display("FAIL alt_count: got %0d words want %0d", cap_acf.size(), NW);
            return;
        end
        for (int l = 0; l < NW; l++) begin
            checks++;
            if (cap_acf[l] !== fconv(ref_acf(l)) || cap_lag[l] != l) begin
                errors++; $display("FAIL alt_w%0d: acf=%h lag=%0d want acf=%h lag=%0d", l, cap_acf[l], cap_lag[l], fconv(ref_acf(l)), l);
            end
        end
        checks++; if (cap_acf[1] !== 32'hC1700000) begin errors++; $display("FAIL alt_lag1: got %h want C1700000", cap_acf[1]); end
        checks++; if (cap_acf[2] !== 32'h41600000) begin errors++; $display("FAIL alt_lag2: got %h want 41600000", cap_acf[2]); end
    endtask

    task automatic test_impulse();
        int tf, tl; bit ok, okw;
        for (int n = 0; n < N; n++) blk[n] = 0;
        blk[0] = -32768;
        clear_cap();
        send_block(0, tf, tl, ok);
        wait_words(NW, okw);
        checks++;
        if (!ok || !okw || cap_acf.size() != NW) begin
            errors++; $display("FAIL imp_count: got %0d words want %0d", cap_acf.size(), NW);
            return;
        end
        checks++; if (cap_acf[0] !== 32'h4E800000) begin errors++; $display("FAIL imp_lag0: got %h want 4E800000", cap_acf[0]); end
        for (int l = 1; l < NW; l++) begin
            checks++;
            if (cap_acf[l] !== 32'h0) begin errors++; $display("FAIL imp_lag%0d: got %h want 00000000", l, cap_acf[l]); end
        end
    endtask

    task automatic test_random();
        int tf, tl; bit ok, okw;
        rand_gaps = 1;
        for (int b = 0; b < 4; b++) begin
            for (int n = 0; n < N; n++) blk[n] = (b == 3) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
            clear_cap();
            send_block(0, tf, tl, ok);
            wait_words(NW, okw);
            checks++;
            if (!ok || !okw || cap_acf.size() != NW) begin
                errors++; $display("FAIL rand%0d_count: got %0d words want %0d", b, cap_acf.size(), NW);
                continue;
            end
            for (int l = 0; l < NW; l++) begin
                checks++;
                if (cap_acf[l] !== fconv(ref_acf(l)) || cap_lag[l] != l || cap_done[l] != (l == ORD) || cap_cyc[l] != tl + 2 + l) begin
                    errors++;
                    $display("FAIL rand%0d_w%0d: acf=%h lag=%0d done=%0b cyc=%0d want acf=%h lag=%0d cyc=%0d",
                             b, l, cap_acf[l], cap_lag[l], cap_done[l], cap_cyc[l] - tl, fconv(ref_acf(l)), l, 2 + l);
                end
            end
        end
        rand_gaps = 0;
    endtask

    task automatic test_back_to_back();
        int t1f, t1l, t2f, t2l; bit ok1, ok2, okw;
        logic [31:0] exp1[NW];
        for (int n = 0; n < N; n++) blk[n] = int'($urandom_range(0, 65535)) - 32768;
        for (int l = 0; l < NW; l++) exp1[l] = fconv(ref_acf(l));
        clear_cap();
        send_block(1, t1f, t1l, ok1);
        for (int n = 0; n < N; n++) blk[n] = 1;
        send_block(0, t2f, t2l, ok2);
        wait_words(2 * NW, okw);
        checks++;
        if (!ok1 || !ok2 || !okw || cap_acf.size() != 2 * NW) begin
            errors++; $display("FAIL b2b_count: got %0d words want %0d", cap_acf.size(), 2 * NW);
            return;
        end
        checks++;
        if (t2f != t1l + ORD + 3) begin errors++; $display("FAIL b2b_first_accept: got T+%0d want T+%0d", t2f - t1l, ORD + 3); end
        for (int l = 0; l < NW; l++) begin
            checks++;
            if (cap_acf[l] !== exp1[l] || cap_acf[NW + l] !== fconv(ref_acf(l)) || cap_lag[NW + l] != l) begin
                errors++; $display("FAIL b2b_w%0d: blk1=%h blk2=%h lag=%0d want blk1=%h blk2=%h lag=%0d",
                                   l, cap_acf[l], cap_acf[NW + l], cap_lag[NW + l], exp1[l], fconv(ref_acf(l)), l);
            end
        end
        for (int c = t1l + 1; c <= t1l + ORD + 2; c++) begin
            checks++;
            if (rdy_hist[c] != 1'b0) begin errors++; $display("FAIL b2b_rdy_c%0d: got 1 want 0", c - t1l); end
        end
    endtask

    task automatic test_enable_stall();
        int tf, tl, budget; bit ok, okw;
        logic [31:0] exp5;
        for (int n = 0; n < N; n++) blk[n] = int'($urandom_range(0, 65535)) - 32768;
        exp5 = fconv(ref_acf(5));
        clear_cap();
        send_block(0, tf, tl, ok);
        budget = 0;
        while (!(ovld && olag == 4'd4) && budget < 50) begin @(negedge clk); #1; budget++; end
        checks++;
        if (budget >= 50) begin errors++; $display("FAIL stall_find_lag4: not seen within %0d cycles", budget); return; end
        @(posedge clk); #1;
        en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checks++;
            if (ovld !== 1'b1 || olag !== 4'd5 || oacf !== exp5 || odone !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: vld=%b lag=%0d acf=%h done=%b want vld=1 lag=5 acf=%h done=0",
                                   k, ovld, olag, oacf, odone, exp5);
            end
            @(posedge clk); #1;
        end
        en = 1;
        wait_words(NW, okw);
        checks++;
        if (!ok || !okw || cap_acf.size() != NW) begin
            errors++; $display("FAIL stall_count: got %0d words want %0d", cap_acf.size(), NW);
            return;
        end
        for (int l = 0; l < NW; l++) begin
            checks++;
            if (cap_acf[l] !== fconv(ref_acf(l)) || cap_lag[l] != l || cap_done[l] != (l == ORD)) begin
                errors++; $display("FAIL stall_w%0d: acf=%h lag=%0d done=%0b want acf=%h lag=%0d", l, cap_acf[l], cap_lag[l], cap_done[l], fconv(ref_acf(l)), l);
            end
        end
    endtask

    task automatic test_reset_mid();
        int tf, tl, budget; bit ok, okw;
        for (int n = 0; n < N; n++) blk[n] = 1;
        clear_cap();
        send_block(0, tf, tl, ok);
        budget = 0;
        while (!(ovld && olag == 4'd4) && budget < 50) begin @(negedge clk); #1; budget++; end
        checks++;
        if (budget >= 50) begin errors++; $display("FAIL rstmid_find_lag4: not seen within %0d cycles", budget); return; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
        checks++;
        if (ovld !== 1'b0 || rdy !== 1'b1 || odone !== 1'b0) begin
            errors++; $display("FAIL rstmid_after: vld=%b rdy=%b done=%b want vld=0 rdy=1 done=0", ovld, rdy, odone);
        end
        clear_cap();
        send_block(0, tf, tl, ok);
        wait_words(NW, okw);
        checks++;
        if (!ok || !okw || cap_acf.size() != NW) begin
            errors++; $display("FAIL rstmid_count: got %0d words want %0d", cap_acf.size(), NW);
            return;
        end
        for (int l = 0; l < NW; l++) begin
            checks++;
            if (cap_acf[l] !== fconv(ref_acf(l)) || cap_lag[l] != l || cap_cyc[l] != tl + 2 + l) begin
                errors++; $display("FAIL rstmid_w%0d: acf=%h lag=%0d cyc=T+%0d want acf=%h lag=%0d cyc=T+%0d",
                                   l, cap_acf[l], cap_lag[l], cap_cyc[l] - tl, fconv(ref_acf(l)), l, 2 + l);
            end
        end
        checks++; if (cap_acf[0] !== 32'h41800000) begin errors++; $display("FAIL rstmid_lag0: got %h want 41800000", cap_acf[0]); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_ones();
        test_alternating();
        test_impulse();
        test_random();
        test_back_to_back();
        test_enable_stall();
        test_reset_mid();
        checks++;
        if (stray_done != 0) begin errors++; $display("FAIL done_outside_valid: got %0d cycles want 0", stray_done); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
